// File: rtl/fb_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_port_arbiter_pkg
// Description : Shared definitions for the framebuffer port-A arbiter:
//               arbiter state encoding and the RAM geometry that is also
//               used by dp_ram and the CPU.
// Revision    : 1.0 - initial release
// ============================================================================
package fb_port_arbiter_pkg;

    // Framebuffer RAM geometry, shared with dp_ram and cpu
    localparam int c_FB_ADDR_W = 17;
    localparam int c_FB_DATA_W = 32;

    // Arbiter FSM encoding: no owner, or a locked burst owned by master 0/1
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t c_IDLE = 2'd0;
    localparam arb_state_t c_OWN0 = 2'd1;
    localparam arb_state_t c_OWN1 = 2'd2;

endpackage
`default_nettype wire

// File: rtl/fb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : fb_port_arbiter_if
// Description : Master-side bus of the framebuffer port-A arbiter. Carries
//               both requesters' request/lock/address/data signals and the
//               returned grants, read-valids and shared read data.
// Revision    : 1.0 - initial release
// ============================================================================
interface fb_port_arbiter_if
    import fb_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = c_FB_ADDR_W,
    parameter int DATA_W = c_FB_DATA_W
);
    logic              req0;
    logic              req1;
    logic              lock0;
    logic              lock1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata;

    // Requester side
    modport master (
        output req0, req1, lock0, lock1, we0, we1,
        output addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata
    );

    // Arbiter side
    modport slave (
        input  req0, req1, lock0, lock1, we0, we1,
        input  addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata
    );

endinterface
`default_nettype wire

// File: rtl/fb_port_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : fb_rr_pick
// Description : Combinational two-way round-robin picker. A lone requester
//               wins; on a tie the master that did not win last time wins.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_rr_pick (
    input  wire logic req0,
    input  wire logic req1,
    input  wire logic last_winner,
    output logic      winner,
    output logic      any
);

    // Winner index is 0 when only req0 (or nobody) requests
    always_comb begin
        any = req0 | req1;
        if (req0 && req1) begin
            winner = ~last_winner;
        end else begin
            winner = req1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fb_port_arbiter
// Description : Shares framebuffer dual-port RAM port A between the CPU
//               (master 0) and the vector/blitter engine (master 1).
//               Round-robin with optional locked bursts of up to MAX_BURST
//               grants; same-cycle grant, read data routed back one cycle
//               later with a per-master rvalid.
//               Optional macro FB_ARB_STATS_EN adds saturating grant/stall
//               counters per master.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_port_arbiter
    import fb_port_arbiter_pkg::*;
#(
    parameter int ADDR_W    = c_FB_ADDR_W,
    parameter int DATA_W    = c_FB_DATA_W,
    parameter int MAX_BURST = 8
`ifdef FB_ARB_STATS_EN
    ,
    parameter int CNT_W     = 32
`endif
) (
    input  wire logic              clk,
    input  wire logic              reset,
    fb_port_arbiter_if.slave       bus,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_din,
    output logic                   mem_w,
    input  wire logic [DATA_W-1:0] mem_dout
`ifdef FB_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]       grant_cnt0,
    output logic [CNT_W-1:0]       grant_cnt1,
    output logic [CNT_W-1:0]       stall_cnt0,
    output logic [CNT_W-1:0]       stall_cnt1
`endif
);

    localparam int              c_BW         = $clog2(MAX_BURST + 1);
    localparam logic [c_BW-1:0] c_BURST_LAST = c_BW'(MAX_BURST);

    arb_state_t      r_state;
    logic            r_last_winner;
    logic [c_BW-1:0] r_burst_cnt;
    logic            r_rvalid0;
    logic            r_rvalid1;

    logic            w_pick_winner;
    logic            w_pick_any;
    logic            w_hold0;
    logic            w_hold1;
    logic            w_win;
    logic            w_any;
    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_win_lock;
    logic [c_BW-1:0] w_cnt_inc;

    fb_rr_pick u_pick (
        .req0        (bus.req0),
        .req1        (bus.req1),
        .last_winner (r_last_winner),
        .winner      (w_pick_winner),
        .any         (w_pick_any)
    );

    // A still-requesting burst owner keeps the port; otherwise round-robin
    // decides, which also covers an owner that just dropped its request.
    // Nothing is granted while reset is held, so no write can slip through.
    always_comb begin
        w_hold0 = (r_state == c_OWN0) && bus.req0;
        w_hold1 = (r_state == c_OWN1) && bus.req1;
        if (w_hold0) begin
            w_win = 1'b0;
            w_any = 1'b1;
        end else if (w_hold1) begin
            w_win = 1'b1;
            w_any = 1'b1;
        end else begin
            w_win = w_pick_winner;
            w_any = w_pick_any;
        end
        w_any      = w_any & ~reset;
        w_gnt0     = w_any & ~w_win;
        w_gnt1     = w_any & w_win;
        w_win_lock = w_win ? bus.lock1 : bus.lock0;
        w_cnt_inc  = r_burst_cnt + 1'b1;
    end

    // Steer the granted master onto RAM port A; park at zero when idle
    always_comb begin
        mem_addr = '0;
        mem_din  = '0;
        mem_w    = 1'b0;
        if (w_gnt0) begin
            mem_addr = bus.addr0;
            mem_din  = bus.wdata0;
            mem_w    = bus.we0;
        end else if (w_gnt1) begin
            mem_addr = bus.addr1;
            mem_din  = bus.wdata1;
            mem_w    = bus.we1;
        end
    end

    assign bus.gnt0    = w_gnt0;
    assign bus.gnt1    = w_gnt1;
    assign bus.rvalid0 = r_rvalid0;
    assign bus.rvalid1 = r_rvalid1;
    assign bus.rdata   = mem_dout;

    // Ownership FSM, burst length tracking and read-valid pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_IDLE;
            r_last_winner <= 1'b1;
            r_burst_cnt   <= '0;
            r_rvalid0     <= 1'b0;
            r_rvalid1     <= 1'b0;
        end else begin
            r_rvalid0 <= w_gnt0 & ~bus.we0;
            r_rvalid1 <= w_gnt1 & ~bus.we1;
            if (w_any) begin
                r_last_winner <= w_win;
            end
            if (w_hold0 || w_hold1) begin
                if (!w_win_lock || (w_cnt_inc == c_BURST_LAST)) begin
                    r_state     <= c_IDLE;
                    r_burst_cnt <= '0;
                end else begin
                    r_burst_cnt <= w_cnt_inc;
                end
            end else if (w_any && w_win_lock && (MAX_BURST > 1)) begin
                r_state     <= w_win ? c_OWN1 : c_OWN0;
                r_burst_cnt <= c_BW'(1);
            end else begin
                r_state     <= c_IDLE;
                r_burst_cnt <= '0;
            end
        end
    end

`ifdef FB_ARB_STATS_EN
    logic [CNT_W-1:0] r_grant_cnt0;
    logic [CNT_W-1:0] r_grant_cnt1;
    logic [CNT_W-1:0] r_stall_cnt0;
    logic [CNT_W-1:0] r_stall_cnt1;

    // Saturating per-master grant and stall statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant_cnt0 <= '0;
            r_grant_cnt1 <= '0;
            r_stall_cnt0 <= '0;
            r_stall_cnt1 <= '0;
        end else begin
            if (w_gnt0 && !(&r_grant_cnt0)) r_grant_cnt0 <= r_grant_cnt0 + 1'b1;
            if (w_gnt1 && !(&r_grant_cnt1)) r_grant_cnt1 <= r_grant_cnt1 + 1'b1;
            if (bus.req0 && !w_gnt0 && !(&r_stall_cnt0)) r_stall_cnt0 <= r_stall_cnt0 + 1'b1;
            if (bus.req1 && !w_gnt1 && !(&r_stall_cnt1)) r_stall_cnt1 <= r_stall_cnt1 + 1'b1;
        end
    end

    assign grant_cnt0 = r_grant_cnt0;
    assign grant_cnt1 = r_grant_cnt1;
    assign stall_cnt0 = r_stall_cnt0;
    assign stall_cnt1 = r_stall_cnt1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_port_arbiter
// Description : Self-checking bench for fb_port_arbiter. A reference model
//               of the arbitration rules and RAM contents is compared with
//               the DUT every cycle; directed sequences pin key cycles with
//               literal expectations. Honours FB_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_port_arbiter;

    localparam int AW = 17;
    localparam int DW = 32;
    localparam int MB = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout = '0;
    logic          mem_w;
`ifdef FB_ARB_STATS_EN
    logic [31:0]   gc0, gc1, sc0, sc1;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fb_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    fb_port_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MAX_BURST (MB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_w    (mem_w),
        .mem_dout (mem_dout)
`ifdef FB_ARB_STATS_EN
        ,
        .grant_cnt0 (gc0),
        .grant_cnt1 (gc1),
        .stall_cnt0 (sc0),
        .stall_cnt1 (sc1)
`endif
    );

    // Power-up RAM contents: every word holds a pattern derived from its address
    function automatic logic [DW-1:0] initval(input logic [AW-1:0] a);
        return 32'hA5A50000 ^ {15'd0, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // dp_ram port A stand-in: 1-cycle synchronous read, write at the edge
    logic [DW-1:0] ram [logic [AW-1:0]];
    always @(posedge clk) begin
        mem_dout <= ram.exists(mem_addr) ? ram[mem_addr] : initval(mem_addr);
        if (mem_w) ram[mem_addr] = mem_din;
    end

    // Reference model: owner (-1 none), run length of owner, last winner
    int            m_owner = -1;
    int            m_run   = 0;
    int            m_last  = 1;
    logic          m_rv0   = 1'b0;
    logic          m_rv1   = 1'b0;
    logic [DW-1:0] m_rdexp = '0;
    logic [DW-1:0] mm [logic [AW-1:0]];

    // Every cycle: derive who must win from the rules, compare, then advance
    always @(negedge clk) begin : b_model
        int            win;
        logic          wwe;
        logic          wlock;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdat;
        win = -1;
        if (!reset) begin
            if (m_owner == 0 && bus.req0)      win = 0;
            else if (m_owner == 1 && bus.req1) win = 1;
            else if (bus.req0 && bus.req1)     win = 1 - m_last;
            else if (bus.req0)                 win = 0;
            else if (bus.req1)                 win = 1;
        end
        wwe   = (win == 0) ? bus.we0    : bus.we1;
        wlock = (win == 0) ? bus.lock0  : bus.lock1;
        waddr = (win == 0) ? bus.addr0  : bus.addr1;
        wdat  = (win == 0) ? bus.wdata0 : bus.wdata1;

        chk("m_gnt0", bus.gnt0, win == 0);
        chk("m_gnt1", bus.gnt1, win == 1);
        chk("m_mem_w", mem_w, (win >= 0) && wwe);
        if (win >= 0) begin
            chk("m_mem_addr", mem_addr, waddr);
            if (wwe) chk("m_mem_din", mem_din, wdat);
        end
        chk("m_rvalid0", bus.rvalid0, m_rv0);
        chk("m_rvalid1", bus.rvalid1, m_rv1);
        if (m_rv0 || m_rv1) chk("m_rdata", bus.rdata, m_rdexp);

        if (reset) begin
            m_owner = -1;
            m_run   = 0;
            m_last  = 1;
            m_rv0   = 1'b0;
            m_rv1   = 1'b0;
        end else begin
            m_rv0 = (win == 0) && !wwe;
            m_rv1 = (win == 1) && !wwe;
            if (win >= 0 && !wwe) m_rdexp = mm.exists(waddr) ? mm[waddr] : initval(waddr);
            if (win >= 0 && wwe) mm[waddr] = wdat;
            if (win >= 0) begin
                m_run  = (win == m_owner) ? m_run + 1 : 1;
                m_last = win;
                m_owner = (wlock && m_run < MB) ? win : -1;
            end else begin
                m_owner = -1;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.lock0 = 1'b0; bus.lock1 = 1'b0;
        bus.we0 = 1'b0; bus.we1 = 1'b0; bus.addr0 = '0; bus.addr1 = '0;
        bus.wdata0 = '0; bus.wdata1 = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_gnt0", bus.gnt0, 1'b0);
        chk("rst_gnt1", bus.gnt1, 1'b0);
        chk("rst_mem_w", mem_w, 1'b0);
        chk("rst_mem_addr", mem_addr, 17'h0);
        chk("rst_mem_din", mem_din, 32'h0);
        chk("rst_rvalid0", bus.rvalid0, 1'b0);
        chk("rst_rvalid1", bus.rvalid1, 1'b0);

        // Both reading, no lock: strict alternation starting with master 0
        next_cycle();
        reset = 1'b0;
        bus.req0 = 1'b1; bus.addr0 = 17'd5;
        bus.req1 = 1'b1; bus.addr1 = 17'd9;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("alt_gnt0", bus.gnt0, (k % 2) == 1);
            chk("alt_gnt1", bus.gnt1, (k % 2) == 0);
            if (k == 2) begin
                chk("alt_rvalid0", bus.rvalid0, 1'b1);
                chk("alt_rdata", bus.rdata, 32'hA5A50005);
            end
            next_cycle();
            if (k == 10) begin
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
        end
        @(negedge clk);
`ifdef FB_ARB_STATS_EN
        chk("stat_grant0", gc0, 32'd5);
        chk("stat_grant1", gc1, 32'd5);
        chk("stat_stall0", sc0, 32'd5);
        chk("stat_stall1", sc1, 32'd5);
`endif

        // Master 1 writes the top address, then reads it back
        next_cycle();
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 17'h1FFFF; bus.wdata1 = 32'hDEADBEEF;
        @(negedge clk);
        chk("wr_gnt1", bus.gnt1, 1'b1);
        chk("wr_mem_w", mem_w, 1'b1);
        chk("wr_mem_addr", mem_addr, 17'h1FFFF);
        chk("wr_mem_din", mem_din, 32'hDEADBEEF);
        next_cycle();
        bus.we1 = 1'b0;
        @(negedge clk);
        chk("rd_gnt1", bus.gnt1, 1'b1);
        chk("rd_mem_w", mem_w, 1'b0);
        next_cycle();
        bus.req1 = 1'b0;
        @(negedge clk);
        chk("rd_rvalid1", bus.rvalid1, 1'b1);
        chk("rd_rdata", bus.rdata, 32'hDEADBEEF);
        chk("rd_rvalid0", bus.rvalid0, 1'b0);

        // Locked burst by master 0 against a waiting master 1
        next_cycle();
        bus.req0 = 1'b1; bus.lock0 = 1'b1; bus.addr0 = 17'h00020;
        bus.req1 = 1'b1; bus.addr1 = 17'd9;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk("burst_gnt0", bus.gnt0, k <= MB);
            chk("burst_gnt1", bus.gnt1, k == MB + 1);
            next_cycle();
            if (k == 9) begin
                bus.req0 = 1'b0; bus.lock0 = 1'b0; bus.req1 = 1'b0;
            end
        end

        // Owner drops its request: the other master is served the same cycle
        bus.req0 = 1'b1; bus.lock0 = 1'b1;
        @(negedge clk);
        chk("drop_start_gnt0", bus.gnt0, 1'b1);
        next_cycle();
        bus.req1 = 1'b1;
        @(negedge clk);
        chk("drop_hold_gnt0", bus.gnt0, 1'b1);
        chk("drop_hold_gnt1", bus.gnt1, 1'b0);
        next_cycle();
        bus.req0 = 1'b0; bus.lock0 = 1'b0;
        @(negedge clk);
        chk("drop_gnt1", bus.gnt1, 1'b1);
        chk("drop_gnt0", bus.gnt0, 1'b0);
        next_cycle();
        bus.req1 = 1'b0;
        @(negedge clk);

        // Reset in the middle of a master-1 burst that has issued a read
        next_cycle();
        bus.req1 = 1'b1; bus.lock1 = 1'b1; bus.addr1 = 17'd9;
        @(negedge clk);
        chk("rb_gnt1", bus.gnt1, 1'b1);
        next_cycle();
        reset = 1'b1;
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 17'd3; bus.wdata0 = 32'h12345678;
        @(negedge clk);
        chk("rb_rst_gnt0", bus.gnt0, 1'b0);
        chk("rb_rst_gnt1", bus.gnt1, 1'b0);
        chk("rb_rst_mem_w", mem_w, 1'b0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("rb_rvalid1", bus.rvalid1, 1'b0);
        chk("rb_tie_gnt0", bus.gnt0, 1'b1);
        chk("rb_tie_gnt1", bus.gnt1, 1'b0);
        next_cycle();
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.req1 = 1'b0; bus.lock1 = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Shares framebuffer dual-port RAM port A (17-bit word address, 32-bit data, 1-cycle synchronous read) between two masters: requester 0 = CPU, requester 1 = vector/blitter engine.
- Sits between the masters and dp_ram port A in the top level; port B stays dedicated to VGA scan-out.
- Round-robin arbitration with optional locked bursts; issues at most one RAM access per cycle and routes read data back to the issuing master.

Parameters:
- ADDR_W, 17, RAM word-address width
- DATA_W, 32, RAM data width
- MAX_BURST, 8, maximum consecutive grants one locked owner may hold (>=1)
- CNT_W, 32, width of the statistics counters (optional feature only)

Ports:
- clk  in  1  system clock, same clock as dp_ram
- reset  in  1  synchronous, active-high reset
- req0 / req1  in  1  access request, held until granted
- lock0 / lock1  in  1  request to keep ownership on the next cycle (burst)
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  word address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  access issued this cycle (combinational)
- rvalid0 / rvalid1  out  1  read data valid for this master (registered)
- rdata  out  DATA_W  read data, pass-through of mem_dout
- mem_addr  out  ADDR_W  to dp_ram addr_a
- mem_din  out  DATA_W  to dp_ram din_a
- mem_w  out  1  to dp_ram write enable
- mem_dout  in  DATA_W  from dp_ram dout_a

Behaviour:
- One clock (clk); reset synchronous, active-high. Reset: state IDLE, last_winner=1 (master 0 wins first tie), burst_cnt=0, rvalid0/1=0. Gnt and mem_* are combinational and follow the reset state: gnt0/1=0, mem_w=0, mem_addr=0, mem_din=0.
- FSM states:
  - IDLE: no owner.
  - OWN0 / OWN1: master holds a locked burst.
- IDLE:
  - Only one master requesting: that master is granted.
  - Both requesting: the master != last_winner is granted.
  - The grant is same-cycle: gnt=1, and mem_addr/mem_din/mem_w are driven from that master's inputs. mem_w = we & gnt.
  - last_winner <= winner.
  - If the winner's lock=1 and MAX_BURST>1: go to OWNx with burst_cnt=1. Otherwise stay in IDLE.
- OWNx:
  - If reqx=1, grant x unconditionally and increment burst_cnt.
  - If lockx=0, or burst_cnt+1 == MAX_BURST, return to IDLE, so the other master gets the next tie.
  - If reqx=0 (owner dropped its request), return to IDLE in the same cycle, and the other master is arbitrated as in IDLE, with no dead cycle.
- Reads: rvalidx <= gntx & ~wex. Data on the next cycle equals mem_dout (dp_ram 1-cycle latency). Back-to-back reads give one rvalid per cycle.
- Writes: no response. RAM is written at the granting edge.
- The master not granted sees gnt=0 and must hold req/addr/wdata/we stable.
- Simultaneous write and read of the same address by different masters cannot occur (single port). A read issued the cycle after a write to the same address returns the new data.
- Starvation bound: a requester waits at most MAX_BURST cycles.
- Reset asserted mid-burst: returns to IDLE next edge and drops the pending rvalid. No RAM write occurs in any cycle where reset=1.

Optional Feature:
- Macro FB_ARB_STATS_EN.
- Defined:
  - Adds outputs grant_cnt0, grant_cnt1, stall_cnt0, stall_cnt1 (CNT_W each).
  - grant_cntx increments on each gntx.
  - stall_cntx increments each cycle with reqx=1 and gntx=0.
  - All counters clear on reset and saturate at all-ones.
- Undefined: these ports and counters do not exist, and arbitration behaviour is identical.

Decomposition:
- Shared package holds the FSM state encoding (IDLE/OWN0/OWN1) and default ADDR_W/DATA_W constants shared with dp_ram and cpu.
- One natural sub-module: fb_rr_pick, a combinational 2-way round-robin picker (req0, req1, last_winner -> winner, any).

Test Plan:
- After reset, req0=req1=1 read, addr0=5, addr1=9, no lock -> gnt0 cycle 1, gnt1 cycle 2, gnt0 cycle 3 (alternating); rvalid0 with RAM[5] one cycle after each gnt0.
- Only req1=1, we1=1, addr1=0x1FFFF, wdata1=0xDEADBEEF, then read -> mem_w=1 at addr 0x1FFFF; read returns 0xDEADBEEF with rvalid1, rvalid0 stays 0.
- Master 0 lock0=1 with req held, req1=1, MAX_BURST=8 -> exactly 8 consecutive gnt0, then gnt1 on the 9th cycle.
- Owner in OWN0 drops req0 while req1=1 -> gnt1 in that same cycle, no idle gap.
- Reset pulsed during an OWN1 burst with a read issued -> next cycle gnt=0, rvalid1=0, state IDLE; the following tie goes to master 0.
- With FB_ARB_STATS_EN: 10 cycles of both requesting, no lock -> grant_cnt0=5, grant_cnt1=5, stall_cnt0=5, stall_cnt1=5.
